// File: rtl/tennis_score_encoder_if.sv
// Point/new-match strobes in, segment image and match status out.
// The master modport drives the strobes and the slave modport drives the display and status.
interface tennis_score_encoder_if;
    logic        point_p1;
    logic        point_p2;
    logic        new_match;
    logic [55:0] C_Out;
    logic [7:0]  AN_Out;
    logic        match_over;
    logic        winner;

    modport master (
        output point_p1, point_p2, new_match,
        input  C_Out, AN_Out, match_over, winner
    );

    modport slave (
        input  point_p1, point_p2, new_match,
        output C_Out, AN_Out, match_over, winner
    );
endinterface

// File: rtl/tennis_score_encoder.sv
// Tennis game/set scorekeeper rendering an 8-digit seven-segment image.
// The display registers trail the score state by one clock.
module tennis_score_encoder #(
    parameter int GAMES_WIN    = 6,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic                    clk,
    input  logic                    rst,
    tennis_score_encoder_if.slave   bus
);
    localparam int          CW     = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [3:0]  GW4    = 4'(GAMES_WIN);
    localparam logic [3:0]  GW4P1  = 4'(GAMES_WIN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCORE = 2'd0,
        ST_DEUCE = 2'd1,
        ST_ADV1  = 2'd2,
        ST_ADV2  = 2'd3
    } gstate_t;

    gstate_t       state_q, state_d;
    logic [1:0]    p1_pts_q, p1_pts_d, p2_pts_q, p2_pts_d;
    logic [2:0]    p1_games_q, p1_games_d, p2_games_q, p2_games_d;
    logic          match_over_q, match_over_d, winner_q, winner_d;
    logic [CW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;
    logic [55:0]   c_out_q, c_out_d;
    logic [7:0]    an_out_q, an_out_d;

    logic          win_s, scorer2_s;
    logic [2:0]    new_games_s, opp_games_s;
    logic [13:0]   f1_s, f2_s;

    function automatic logic [6:0] seg_digit(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Two-digit rendering of a regular point count: tens digit in the upper half.
    function automatic logic [13:0] pts_field(input logic [1:0] p);
        logic [13:0] f;
        case (p)
            2'd0:    f = {seg_digit(4'd0), seg_digit(4'd0)};
            2'd1:    f = {seg_digit(4'd1), seg_digit(4'd5)};
            2'd2:    f = {seg_digit(4'd3), seg_digit(4'd0)};
            2'd3:    f = {seg_digit(4'd4), seg_digit(4'd0)};
            default: f = 14'h0000;
        endcase
        return f;
    endfunction

    // Next-state: match restart, blink timing, point scoring and set detection.
    always_comb begin
        state_d      = state_q;
        p1_pts_d     = p1_pts_q;
        p2_pts_d     = p2_pts_q;
        p1_games_d   = p1_games_q;
        p2_games_d   = p2_games_q;
        match_over_d = match_over_q;
        winner_d     = winner_q;
        blink_cnt_d  = blink_cnt_q;
        blink_ph_d   = blink_ph_q;
        win_s        = 1'b0;
        scorer2_s    = bus.point_p2;
        new_games_s  = 3'd0;
        opp_games_s  = 3'd0;
        if (bus.new_match) begin
            state_d      = ST_SCORE;
            p1_pts_d     = 2'd0;
            p2_pts_d     = 2'd0;
            p1_games_d   = 3'd0;
            p2_games_d   = 3'd0;
            match_over_d = 1'b0;
            winner_d     = 1'b0;
            blink_cnt_d  = '0;
            blink_ph_d   = 1'b0;
        end else if (match_over_q) begin
            if (blink_cnt_q == CNT_LAST) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CW'(1);
            end
        end else if (bus.point_p1 ^ bus.point_p2) begin
            case (state_q)
                ST_SCORE: begin
                    if (scorer2_s) begin
                        if (p2_pts_q == 2'd3) begin
                            win_s = 1'b1;
                        end else if (p2_pts_q == 2'd2 && p1_pts_q == 2'd3) begin
                            state_d = ST_DEUCE;
                        end else begin
                            p2_pts_d = p2_pts_q + 2'd1;
                        end
                    end else begin
                        if (p1_pts_q == 2'd3) begin
                            win_s = 1'b1;
                        end else if (p1_pts_q == 2'd2 && p2_pts_q == 2'd3) begin
                            state_d = ST_DEUCE;
                        end else begin
                            p1_pts_d = p1_pts_q + 2'd1;
                        end
                    end
                end
                ST_DEUCE: state_d = scorer2_s ? ST_ADV2 : ST_ADV1;
                ST_ADV1:  begin
                    if (scorer2_s) begin
                        state_d = ST_DEUCE;
                    end else begin
                        win_s = 1'b1;
                    end
                end
                ST_ADV2:  begin
                    if (scorer2_s) begin
                        win_s = 1'b1;
                    end else begin
                        state_d = ST_DEUCE;
                    end
                end
                default:  state_d = ST_SCORE;
            endcase
            // Points are not needed outside SCORE, so any exit from SCORE clears them.
            if (win_s || state_d != ST_SCORE) begin
                p1_pts_d = 2'd0;
                p2_pts_d = 2'd0;
            end else begin
                state_d = ST_SCORE;
            end
            if (win_s) begin
                state_d     = ST_SCORE;
                new_games_s = scorer2_s ? (p2_games_q + 3'd1) : (p1_games_q + 3'd1);
                opp_games_s = scorer2_s ? p1_games_q : p2_games_q;
                if (scorer2_s) begin
                    p2_games_d = new_games_s;
                end else begin
                    p1_games_d = new_games_s;
                end
                if (({1'b0, new_games_s} >= GW4 && {1'b0, new_games_s} >= ({1'b0, opp_games_s} + 4'd2))
                    || {1'b0, new_games_s} == GW4P1) begin
                    match_over_d = 1'b1;
                    winner_d     = scorer2_s;
                end else begin
                    match_over_d = 1'b0;
                end
            end else begin
                match_over_d = match_over_q;
            end
        end else begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end
    end

    // Display image from the current score; digit 7 is the leftmost.
    always_comb begin
        f1_s = pts_field(p1_pts_q);
        f2_s = pts_field(p2_pts_q);
        case (state_q)
            ST_SCORE: begin
                f1_s = pts_field(p1_pts_q);
                f2_s = pts_field(p2_pts_q);
            end
            ST_DEUCE: begin
                f1_s = {7'h5E, 7'h79};
                f2_s = {7'h5E, 7'h79};
            end
            ST_ADV1: begin
                f1_s = {7'h77, 7'h5E};
                f2_s = {7'h40, 7'h40};
            end
            ST_ADV2: begin
                f1_s = {7'h40, 7'h40};
                f2_s = {7'h77, 7'h5E};
            end
            default: begin
                f1_s = 14'h0000;
                f2_s = 14'h0000;
            end
        endcase
        c_out_d = {seg_digit({1'b0, p1_games_q}), f1_s, 7'h00,
                   seg_digit({1'b0, p2_games_q}), f2_s, 7'h00};
        an_out_d = 8'hEE;
        if (match_over_q && blink_ph_q) begin
            if (winner_q) begin
                an_out_d[3] = 1'b0;
            end else begin
                an_out_d[7] = 1'b0;
            end
        end else begin
            an_out_d = 8'hEE;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_SCORE;
            p1_pts_q     <= 2'd0;
            p2_pts_q     <= 2'd0;
            p1_games_q   <= 3'd0;
            p2_games_q   <= 3'd0;
            match_over_q <= 1'b0;
            winner_q     <= 1'b0;
            blink_cnt_q  <= '0;
            blink_ph_q   <= 1'b0;
            c_out_q      <= 56'h0;
            an_out_q     <= 8'h00;
        end else begin
            state_q      <= state_d;
            p1_pts_q     <= p1_pts_d;
            p2_pts_q     <= p2_pts_d;
            p1_games_q   <= p1_games_d;
            p2_games_q   <= p2_games_d;
            match_over_q <= match_over_d;
            winner_q     <= winner_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_ph_q   <= blink_ph_d;
            c_out_q      <= c_out_d;
            an_out_q     <= an_out_d;
        end
    end

    assign bus.C_Out      = c_out_q;
    assign bus.AN_Out     = an_out_q;
    assign bus.match_over = match_over_q;
    assign bus.winner     = winner_q;
endmodule

// File: tb/tb_tennis_score_encoder.sv
// Directed bench for tennis_score_encoder: expected displays are queued and popped one clock after each step.
module tb_tennis_score_encoder;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    tennis_score_encoder_if bus ();

    tennis_score_encoder #(.GAMES_WIN(6), .BLINK_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [55:0] c;
        logic [7:0]  an;
        logic        mo;
        logic        wn;
    } exp_t;

    exp_t sb[$];

    localparam logic [7:0] S0 = 8'h3F, S1 = 8'h06, S3 = 8'h4F, S4 = 8'h66, S5 = 8'h6D,
                           S6 = 8'h7D, S7 = 8'h07, SA = 8'h77, SD = 8'h5E, SE = 8'h79,
                           SM = 8'h40, BL = 8'h00;

    function automatic logic [55:0] img(input logic [7:0] d7, input logic [7:0] d6,
                                        input logic [7:0] d5, input logic [7:0] d4,
                                        input logic [7:0] d3, input logic [7:0] d2,
                                        input logic [7:0] d1, input logic [7:0] d0);
        return {d7[6:0], d6[6:0], d5[6:0], d4[6:0], d3[6:0], d2[6:0], d1[6:0], d0[6:0]};
    endfunction

    task automatic push(input string tag, input logic [55:0] c, input logic [7:0] an,
                        input logic mo, input logic wn);
        exp_t e;
        e.tag = tag; e.c = c; e.an = an; e.mo = mo; e.wn = wn;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=no entry expected=one entry");
        end else begin
            e = sb.pop_front();
            checks++;
            assert (bus.C_Out === e.c) else begin
                errors++;
                $error("FAIL %s C_Out observed=%h expected=%h", e.tag, bus.C_Out, e.c);
            end
            checks++;
            assert (bus.AN_Out === e.an) else begin
                errors++;
                $error("FAIL %s AN_Out observed=%h expected=%h", e.tag, bus.AN_Out, e.an);
            end
            checks++;
            assert (bus.match_over === e.mo) else begin
                errors++;
                $error("FAIL %s match_over observed=%b expected=%b", e.tag, bus.match_over, e.mo);
            end
            checks++;
            assert (bus.winner === e.wn) else begin
                errors++;
                $error("FAIL %s winner observed=%b expected=%b", e.tag, bus.winner, e.wn);
            end
        end
    endtask

    task automatic check_out();
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic pulse(input logic p1, input logic p2, input logic nm);
        bus.point_p1  = p1;
        bus.point_p2  = p2;
        bus.new_match = nm;
        @(posedge clk);
        #1;
        bus.point_p1  = 1'b0;
        bus.point_p2  = 1'b0;
        bus.new_match = 1'b0;
    endtask

    task automatic win_game(input logic p2);
        repeat (4) pulse(~p2, p2, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        bus.point_p1  = 1'b0;
        bus.point_p2  = 1'b0;
        bus.new_match = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push("reset", 56'h0, 8'h00, 1'b0, 1'b0);
        pop_check();

        rst = 1'b1;
        push("idle", img(S0, S0, S0, BL, S0, S0, S0, BL), 8'hEE, 1'b0, 1'b0);
        check_out();

        repeat (3) pulse(1'b1, 1'b0, 1'b0);
        push("p1_40", img(S0, S4, S0, BL, S0, S0, S0, BL), 8'hEE, 1'b0, 1'b0);
        check_out();
        pulse(1'b1, 1'b0, 1'b0);
        push("p1_game", img(S1, S0, S0, BL, S0, S0, S0, BL), 8'hEE, 1'b0, 1'b0);
        check_out();

        repeat (3) begin
            pulse(1'b1, 1'b0, 1'b0);
            pulse(1'b0, 1'b1, 1'b0);
        end
        push("deuce", img(S1, SD, SE, BL, S0, SD, SE, BL), 8'hEE, 1'b0, 1'b0);
        check_out();
        pulse(1'b0, 1'b1, 1'b0);
        push("adv2", img(S1, SM, SM, BL, S0, SA, SD, BL), 8'hEE, 1'b0, 1'b0);
        check_out();
        pulse(1'b1, 1'b0, 1'b0);
        push("back_deuce", img(S1, SD, SE, BL, S0, SD, SE, BL), 8'hEE, 1'b0, 1'b0);
        check_out();
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        push("p2_game", img(S1, S0, S0, BL, S1, S0, S0, BL), 8'hEE, 1'b0, 1'b0);
        check_out();

        pulse(1'b1, 1'b0, 1'b0);
        push("p1_15", img(S1, S1, S5, BL, S1, S0, S0, BL), 8'hEE, 1'b0, 1'b0);
        check_out();
        pulse(1'b1, 1'b1, 1'b0);
        push("both_pts", img(S1, S1, S5, BL, S1, S0, S0, BL), 8'hEE, 1'b0, 1'b0);
        check_out();
        pulse(1'b1, 1'b0, 1'b1);
        push("new_match_prio", img(S0, S0, S0, BL, S0, S0, S0, BL), 8'hEE, 1'b0, 1'b0);
        check_out();

        repeat (6) win_game(1'b0);
        push("p1_set", img(S6, S0, S0, BL, S0, S0, S0, BL), 8'hEE, 1'b1, 1'b0);
        check_out();
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        push("blink_on", img(S6, S0, S0, BL, S0, S0, S0, BL), 8'h6E, 1'b1, 1'b0);
        check_out();
        repeat (3) @(posedge clk);
        push("blink_off", img(S6, S0, S0, BL, S0, S0, S0, BL), 8'hEE, 1'b1, 1'b0);
        check_out();
        repeat (3) @(posedge clk);
        push("blink_on2", img(S6, S0, S0, BL, S0, S0, S0, BL), 8'h6E, 1'b1, 1'b0);
        check_out();

        pulse(1'b0, 1'b0, 1'b1);
        push("restart", img(S0, S0, S0, BL, S0, S0, S0, BL), 8'hEE, 1'b0, 1'b0);
        check_out();
        repeat (5) begin
            win_game(1'b0);
            win_game(1'b1);
        end
        win_game(1'b0);
        push("six_five", img(S6, S0, S0, BL, S5, S0, S0, BL), 8'hEE, 1'b0, 1'b0);
        check_out();
        win_game(1'b1);
        push("six_six", img(S6, S0, S0, BL, S6, S0, S0, BL), 8'hEE, 1'b0, 1'b0);
        check_out();
        win_game(1'b1);
        push("p2_set", img(S6, S0, S0, BL, S7, S0, S0, BL), 8'hEE, 1'b1, 1'b1);
        check_out();
        repeat (3) @(posedge clk);
        push("blink_p2", img(S6, S0, S0, BL, S7, S0, S0, BL), 8'hE6, 1'b1, 1'b1);
        check_out();

        rst = 1'b0;
        @(posedge clk);
        #1;
        push("mid_reset", 56'h0, 8'h00, 1'b0, 1'b0);
        pop_check();
        rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
